// File: rtl/assoc_cache_bram_pkg.sv
// Shared definitions for the set-associative read cache: FSM encoding,
// address-field constants and a width helper.
package assoc_cache_bram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MREQ   = 3'd2,
    ST_REFILL = 3'd3,
    ST_RESP   = 3'd4,
    ST_FLUSH  = 3'd5
  } state_t;

  // Byte-offset bits of the CPU address; accesses are word aligned.
  localparam int BYTE_W = 2;

  // Index width that never collapses to zero, so one-entry fields stay legal.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/assoc_cache_bram_way_ram.sv
// One cache way: tag and line-data arrays, single-port, synchronous read.
// Write and read share the address; the read port always reflects the addressed entry.
module cache_way_ram
  import assoc_cache_bram_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 22,
  parameter int DATA_W     = 32,
  localparam int IDX_W     = clog2_min1(SETS),
  localparam int DADDR_W   = clog2_min1(SETS * LINE_WORDS)
) (
  input  logic               clk,
  input  logic [IDX_W-1:0]   tag_addr,
  input  logic               tag_we,
  input  logic [TAG_W-1:0]   tag_wdata,
  output logic [TAG_W-1:0]   tag_rdata,
  input  logic [DADDR_W-1:0] data_addr,
  input  logic               data_we,
  input  logic [DATA_W-1:0]  data_wdata,
  output logic [DATA_W-1:0]  data_rdata
);

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[tag_addr] <= tag_wdata;
    end
    tag_rdata <= tag_mem[tag_addr];
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[data_addr] <= data_wdata;
    end
    data_rdata <= data_mem[data_addr];
  end

endmodule

// File: rtl/assoc_cache_bram.sv
// N-way set-associative read cache with BRAM tag/data arrays, whole-line refill,
// per-set round-robin replacement, sweep flush and saturating access/hit counters.
module assoc_cache_bram
  import assoc_cache_bram_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              flush,
  output logic              flush_busy,
  output logic [CNT_W-1:0]  access_cnt,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int WOFF_W  = clog2_min1(LINE_WORDS);
  localparam int IDX_W   = clog2_min1(SETS);
  localparam int IDX_LSB = BYTE_W + WOFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam int RR_W    = clog2_min1(WAYS);

  state_t              state_reg, state_next;
  logic [TAG_W-1:0]    tag_reg, tag_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [WOFF_W-1:0]   woff_reg, woff_next;
  logic [WOFF_W-1:0]   beat_reg, beat_next;
  logic [RR_W-1:0]     victim_reg, victim_next;
  logic [IDX_W-1:0]    flush_idx_reg, flush_idx_next;
  logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
  logic                rsp_hit_reg, rsp_hit_next;
  logic [ADDR_W-1:0]   mem_req_addr_reg, mem_req_addr_next;
  logic [CNT_W-1:0]    access_cnt_reg, hit_cnt_reg;
  logic                access_inc, hit_inc;

  logic [WAYS-1:0][TAG_W-1:0]  way_tag;
  logic [WAYS-1:0][DATA_W-1:0] way_data;
  logic [WAYS-1:0]             way_valid, hit_vec, tag_we, data_we;
  logic                        hit_any;
  logic [DATA_W-1:0]           hit_data;
  logic [RR_W-1:0]             rr_cur, victim_sel;
  logic [IDX_W-1:0]            ram_idx;
  logic [WOFF_W-1:0]           ram_woff;
  logic                        fill_last;
  logic                        unused_byte_bits;

  assign unused_byte_bits = ^req_addr[BYTE_W-1:0];

  assign fill_last = (state_reg == ST_REFILL) && mem_rsp_valid && (&beat_reg);

  // Arrays are addressed by the incoming request while idle so the read is
  // ready in LOOKUP; during refill the beat counter selects the word.
  always_comb begin
    ram_idx  = idx_reg;
    ram_woff = woff_reg;
    if (state_reg == ST_IDLE) begin
      ram_idx  = req_addr[TAG_LSB-1:IDX_LSB];
      ram_woff = req_addr[IDX_LSB-1:BYTE_W];
    end else if (state_reg == ST_REFILL) begin
      ram_woff = beat_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [SETS-1:0] valid_reg;

      assign data_we[gi]   = (state_reg == ST_REFILL) && mem_rsp_valid && (victim_reg == RR_W'(gi));
      assign tag_we[gi]    = fill_last && (victim_reg == RR_W'(gi));
      assign way_valid[gi] = valid_reg[idx_reg];
      assign hit_vec[gi]   = way_valid[gi] && (way_tag[gi] == tag_reg);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg <= '0;
        end else if (state_reg == ST_FLUSH) begin
          valid_reg[flush_idx_reg] <= 1'b0;
        end else if (tag_we[gi]) begin
          valid_reg[idx_reg] <= 1'b1;
        end
      end

      cache_way_ram #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
      ) u_ram (
        .clk        (clk),
        .tag_addr   (ram_idx),
        .tag_we     (tag_we[gi]),
        .tag_wdata  (tag_reg),
        .tag_rdata  (way_tag[gi]),
        .data_addr  ({ram_idx, ram_woff}),
        .data_we    (data_we[gi]),
        .data_wdata (mem_rsp_data),
        .data_rdata (way_data[gi])
      );
    end

    if (WAYS > 1) begin : g_rr
      logic [RR_W-1:0] rr_reg [SETS];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++) begin
            rr_reg[s] <= '0;
          end
        end else if (fill_last) begin
          rr_reg[idx_reg] <= (rr_reg[idx_reg] == RR_W'(WAYS-1)) ? '0 : rr_reg[idx_reg] + 1'b1;
        end
      end

      assign rr_cur = rr_reg[idx_reg];
    end else begin : g_rr_const
      assign rr_cur = '0;
    end
  endgenerate

  // Descending scans so the lowest-indexed way wins both searches.
  always_comb begin
    hit_any  = 1'b0;
    hit_data = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit_any  = 1'b1;
        hit_data = way_data[w];
      end
    end
  end

  always_comb begin
    victim_sel = rr_cur;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        victim_sel = RR_W'(w);
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    tag_next          = tag_reg;
    idx_next          = idx_reg;
    woff_next         = woff_reg;
    beat_next         = beat_reg;
    victim_next       = victim_reg;
    flush_idx_next    = flush_idx_reg;
    rsp_data_next     = rsp_data_reg;
    rsp_hit_next      = rsp_hit_reg;
    mem_req_addr_next = mem_req_addr_reg;
    access_inc        = 1'b0;
    hit_inc           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (flush) begin
          state_next     = ST_FLUSH;
          flush_idx_next = '0;
        end else if (req_valid) begin
          state_next = ST_LOOKUP;
          tag_next   = req_addr[ADDR_W-1:TAG_LSB];
          idx_next   = req_addr[TAG_LSB-1:IDX_LSB];
          woff_next  = req_addr[IDX_LSB-1:BYTE_W];
          access_inc = 1'b1;
        end
      end
      ST_LOOKUP: begin
        if (hit_any) begin
          state_next    = ST_RESP;
          rsp_data_next = hit_data;
          rsp_hit_next  = 1'b1;
          hit_inc       = 1'b1;
        end else begin
          state_next        = ST_MREQ;
          victim_next       = victim_sel;
          rsp_hit_next      = 1'b0;
          mem_req_addr_next = {tag_reg, idx_reg, {IDX_LSB{1'b0}}};
        end
      end
      ST_MREQ: begin
        if (mem_req_ready) begin
          state_next = ST_REFILL;
          beat_next  = '0;
        end
      end
      ST_REFILL: begin
        if (mem_rsp_valid) begin
          beat_next = beat_reg + 1'b1;
          if (beat_reg == woff_reg) begin
            rsp_data_next = mem_rsp_data;
          end
          if (&beat_reg) begin
            state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      ST_FLUSH: begin
        flush_idx_next = flush_idx_reg + 1'b1;
        if (&flush_idx_reg) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_IDLE;
      tag_reg          <= '0;
      idx_reg          <= '0;
      woff_reg         <= '0;
      beat_reg         <= '0;
      victim_reg       <= '0;
      flush_idx_reg    <= '0;
      rsp_data_reg     <= '0;
      rsp_hit_reg      <= 1'b0;
      mem_req_addr_reg <= '0;
    end else begin
      state_reg        <= state_next;
      tag_reg          <= tag_next;
      idx_reg          <= idx_next;
      woff_reg         <= woff_next;
      beat_reg         <= beat_next;
      victim_reg       <= victim_next;
      flush_idx_reg    <= flush_idx_next;
      rsp_data_reg     <= rsp_data_next;
      rsp_hit_reg      <= rsp_hit_next;
      mem_req_addr_reg <= mem_req_addr_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      access_cnt_reg <= '0;
      hit_cnt_reg    <= '0;
    end else begin
      if (access_inc && !(&access_cnt_reg)) begin
        access_cnt_reg <= access_cnt_reg + 1'b1;
      end
      if (hit_inc && !(&hit_cnt_reg)) begin
        hit_cnt_reg <= hit_cnt_reg + 1'b1;
      end
    end
  end

  assign req_ready     = (state_reg == ST_IDLE) && !flush;
  assign rsp_valid     = (state_reg == ST_RESP);
  assign rsp_data      = rsp_data_reg;
  assign rsp_hit       = rsp_hit_reg;
  assign mem_req_valid = (state_reg == ST_MREQ);
  assign mem_req_addr  = mem_req_addr_reg;
  assign flush_busy    = (state_reg == ST_FLUSH);
  assign access_cnt    = access_cnt_reg;
  assign hit_cnt       = hit_cnt_reg;

endmodule

// File: tb/tb_assoc_cache_bram.sv
// Directed bench for assoc_cache_bram: vector table of reads plus flush and
// mid-refill reset sequences; a CNT_W=2 twin checks counter saturation.
module tb_assoc_cache_bram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        flush = 1'b0;

  logic        req_ready, rsp_valid, rsp_hit, mem_req_valid, flush_busy;
  logic [31:0] rsp_data, mem_req_addr;
  logic [15:0] access_cnt, hit_cnt;

  logic        unused_s_ready, unused_s_rv, unused_s_hit, unused_s_mrv, unused_s_fb;
  logic [31:0] unused_s_data, unused_s_maddr;
  logic [1:0]  s_access_cnt, s_hit_cnt;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  assoc_cache_bram #(.ADDR_W(32), .DATA_W(32), .SETS(64), .WAYS(2), .LINE_WORDS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .flush(flush), .flush_busy(flush_busy), .access_cnt(access_cnt), .hit_cnt(hit_cnt)
  );

  // Identical stimulus, so it runs in lock step with dut; only counter width differs.
  assoc_cache_bram #(.ADDR_W(32), .DATA_W(32), .SETS(64), .WAYS(2), .LINE_WORDS(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(unused_s_ready), .req_addr(req_addr),
    .rsp_valid(unused_s_rv), .rsp_data(unused_s_data), .rsp_hit(unused_s_hit),
    .mem_req_valid(unused_s_mrv), .mem_req_ready(mem_req_ready), .mem_req_addr(unused_s_maddr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .flush(flush), .flush_busy(unused_s_fb), .access_cnt(s_access_cnt), .hit_cnt(s_hit_cnt)
  );

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic [31:0] base;
    logic [31:0] exp_data;
    logic        exp_hit;
    int          stall;
    int          gap;
    int          exp_acc;
    int          exp_hc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string nm, input logic [31:0] addr, input logic [31:0] base,
                         input logic [31:0] exp_data, input logic exp_hit, input int stall, input int gap,
                         input int exp_acc, input int exp_hc);
    vecs[i].nm = nm; vecs[i].addr = addr; vecs[i].base = base; vecs[i].exp_data = exp_data;
    vecs[i].exp_hit = exp_hit; vecs[i].stall = stall; vecs[i].gap = gap;
    vecs[i].exp_acc = exp_acc; vecs[i].exp_hc = exp_hc;
  endtask

  // Called and returns on a falling edge. Acts as the memory: answers line
  // fetches with base+k on beat k, after `stall` not-ready cycles and `gap` idle cycles between beats.
  task automatic do_read(input string nm, input logic [31:0] addr, input logic [31:0] base,
                         input logic [31:0] exp_data, input logic exp_hit, input int stall, input int gap,
                         input int exp_acc, input int exp_hc, input int abort_beats);
    int acc_e, rsp_e, nrsp, post, mreq_cyc, beats, gapc, stallc;
    logic granted, addr_ok, got_h;
    logic [31:0] got_d;
    acc_e = -1; rsp_e = -1; nrsp = 0; post = 0; mreq_cyc = 0; beats = 0; gapc = 0; stallc = 0;
    granted = 1'b0; addr_ok = 1'b1; got_h = 1'b0; got_d = '0;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int i = 0; i < 20 && acc_e < 0; i++) begin
      if (req_ready) acc_e = edge_cnt + 1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (acc_e < 0) begin
      chk({nm, " accept_timeout"}, 0, 1);
      return;
    end
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid) begin
        if (nrsp == 0) begin
          got_d = rsp_data;
          got_h = rsp_hit;
          rsp_e = edge_cnt + 1;
        end
        nrsp++;
      end
      if (mem_req_valid) begin
        mreq_cyc++;
        if (mem_req_addr !== (addr & ~32'hF)) addr_ok = 1'b0;
      end
      if (nrsp > 0) post++;
      if (post > 3) break;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (mem_req_valid && !granted) begin
        if (stallc < stall) stallc++;
        else begin
          mem_req_ready = 1'b1;
          granted = 1'b1;
        end
      end else if (granted && beats < 4) begin
        if (gapc == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = base + beats;
          beats++;
          gapc = gap;
        end else begin
          gapc--;
        end
      end
      @(negedge clk);
      if (abort_beats > 0 && beats == abort_beats && mem_rsp_valid) begin
        mem_rsp_valid = 1'b0;
        $display("rd %s addr=0x%08h abandoned after %0d beats", nm, addr, beats);
        return;
      end
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    $display("rd %s addr=0x%08h data=0x%0h hit=%0d nrsp=%0d lat=%0d acc=%0d hits=%0d",
             nm, addr, got_d, got_h, nrsp, rsp_e - acc_e, access_cnt, hit_cnt);
    chk({nm, " rsp_count"}, nrsp, 1);
    if (nrsp > 0) begin
      chk({nm, " rsp_data"}, got_d, exp_data);
      chk({nm, " rsp_hit"}, got_h, exp_hit);
    end
    chk({nm, " mem_req_cycles"}, mreq_cyc, exp_hit ? 0 : stall + 1);
    chk({nm, " mem_req_addr_stable"}, addr_ok, 1);
    if (exp_hit) chk({nm, " hit_latency"}, rsp_e - acc_e, 2);
    chk({nm, " access_cnt"}, access_cnt, exp_acc);
    chk({nm, " hit_cnt"}, hit_cnt, exp_hc);
  endtask

  initial begin
    int busy;
    int stray;
    set_vec(0,  "cold_miss",     32'h0000_0010, 32'h0A0, 32'h0A0, 1'b0, 0, 0, 1,  0);
    set_vec(1,  "rehit",         32'h0000_0014, 32'h0,   32'h0A1, 1'b1, 0, 0, 2,  1);
    set_vec(2,  "fill_A",        32'h0000_0000, 32'h100, 32'h100, 1'b0, 0, 0, 3,  1);
    set_vec(3,  "fill_B",        32'h0000_0404, 32'h200, 32'h201, 1'b0, 0, 0, 4,  1);
    set_vec(4,  "fill_C_evictA", 32'h0000_080C, 32'h300, 32'h303, 1'b0, 0, 0, 5,  1);
    set_vec(5,  "B_still_hits",  32'h0000_0408, 32'h0,   32'h202, 1'b1, 0, 0, 6,  2);
    set_vec(6,  "A_misses",      32'h0000_0000, 32'h400, 32'h400, 1'b0, 0, 0, 7,  2);
    set_vec(7,  "C_hits",        32'h0000_0808, 32'h0,   32'h302, 1'b1, 0, 0, 8,  3);
    set_vec(8,  "backpressure",  32'h0000_1238, 32'h500, 32'h502, 1'b0, 5, 3, 9,  3);
    set_vec(9,  "bp_line_hit",   32'h0000_1230, 32'h0,   32'h500, 1'b1, 0, 0, 10, 4);
    set_vec(10, "set1_w0_hit",   32'h0000_0010, 32'h0,   32'h0A0, 1'b1, 0, 0, 11, 5);
    set_vec(11, "set1_w3_hit",   32'h0000_001C, 32'h0,   32'h0A3, 1'b1, 0, 0, 12, 6);

    repeat (3) @(negedge clk);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset mem_req_valid", mem_req_valid, 0);
    chk("reset mem_req_addr", mem_req_addr, 0);
    chk("reset flush_busy", flush_busy, 0);
    chk("reset access_cnt", access_cnt, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset hit_cnt", hit_cnt, 0);

    for (int i = 0; i < 12; i++) begin
      do_read(vecs[i].nm, vecs[i].addr, vecs[i].base, vecs[i].exp_data, vecs[i].exp_hit,
              vecs[i].stall, vecs[i].gap, vecs[i].exp_acc, vecs[i].exp_hc, 0);
    end
    chk("sat access_cnt", s_access_cnt, 3);
    chk("sat hit_cnt", s_hit_cnt, 3);

    // Flush and a request in the same cycle: the flush must win.
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h0000_0014;
    #1;
    chk("flush req_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    busy = 0;
    stray = 0;
    for (int i = 0; i < 200; i++) begin
      if (flush_busy) busy++;
      else if (busy > 0) break;
      if (rsp_valid) stray++;
      @(negedge clk);
    end
    $display("flush busy_cycles=%0d stray_rsp=%0d acc=%0d hits=%0d", busy, stray, access_cnt, hit_cnt);
    chk("flush busy_cycles", busy, 64);
    chk("flush stray_rsp", stray, 0);
    chk("flush access_cnt", access_cnt, 12);
    chk("flush hit_cnt", hit_cnt, 6);
    do_read("after_flush", 32'h0000_0014, 32'h600, 32'h601, 1'b0, 0, 0, 13, 6, 0);

    // Reset lands after the second refill beat.
    do_read("partial", 32'h0000_2040, 32'h700, 32'h700, 1'b0, 0, 0, 14, 6, 2);
    rst = 1'b0;
    #1;
    chk("midreset rsp_valid", rsp_valid, 0);
    chk("midreset rsp_data", rsp_data, 0);
    chk("midreset rsp_hit", rsp_hit, 0);
    chk("midreset mem_req_valid", mem_req_valid, 0);
    chk("midreset mem_req_addr", mem_req_addr, 0);
    chk("midreset flush_busy", flush_busy, 0);
    chk("midreset access_cnt", access_cnt, 0);
    chk("midreset hit_cnt", hit_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset req_ready", req_ready, 1);
    do_read("refill_clean", 32'h0000_2040, 32'h800, 32'h800, 1'b0, 0, 0, 1, 0, 0);
    do_read("refill_hit",   32'h0000_204C, 32'h0,   32'h803, 1'b1, 0, 0, 2, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
